pc_flow_ctrl: RTL and testbench
===============================

Name: pc_flow_ctrl

Overview:
Central flow controller for the PC register and the front pipeline stages.
- Arbitrates redirect requests from EX (branch/jump), CLINT (interrupt/trap entry) and JTAG (reset), plus stall requests from EX, CLINT, the RIB bus and JTAG halt.
- Drives the PC register's jump flag, jump address, hold level and JTAG reset inputs.
- Holds back a redirect while the bus is busy, then holds the front end for a fixed flush window after each redirect.

Parameters:
ADDR_W, 32, instruction address width
RESET_ADDR, 32'h0, PC value restored on redirect abort (reported on jump_addr_o at reset)
FLUSH_CYCLES, 2, cycles hold_flag_o stays at 3'd3 after a jump pulse (range 1..15)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
ex_jump_req_i  in  1  EX redirect request (level, sampled each cycle)
ex_jump_addr_i  in  ADDR_W  EX redirect target
ex_hold_req_i  in  1  EX multicycle stall (divider)
clint_int_req_i  in  1  CLINT trap/interrupt redirect request
clint_int_addr_i  in  ADDR_W  CLINT target (mtvec/mepc)
clint_hold_req_i  in  1  CLINT CSR-write stall
rib_hold_req_i  in  1  bus busy; PC must not advance
jtag_halt_req_i  in  1  debug halt (level)
jtag_reset_req_i  in  1  debug core reset (level)
jump_flag_o  out  1  one-cycle redirect pulse to PC register
jump_addr_o  out  ADDR_W  redirect target, valid while jump_flag_o=1
hold_flag_o  out  3  0=none, 1=hold PC, 2=hold PC+IF, 3=hold PC+IF+ID
jtag_reset_flag_o  out  1  core reset to PC register
halted_o  out  1  core is halted for debug

Behaviour:
- All outputs are registered. Request sampled at edge N → response visible from N+1.
- Reset values: jump_flag_o=0, jump_addr_o=RESET_ADDR, hold_flag_o=0, jtag_reset_flag_o=0, halted_o=0, state=RUN, pending cleared, flush counter=0.
- States: RUN, PEND, JUMP, FLUSH, HALT.
- Redirect priority: jtag_reset > clint_int > ex_jump.
- jtag_reset_req_i=1 in any state:
  - next cycle jtag_reset_flag_o=1, jump_flag_o=0, hold_flag_o=3.
  - pending redirect discarded; state→RUN.
  - jtag_reset_flag_o follows the request with 1-cycle delay; hold_flag_o returns to 0 the cycle after the request drops.
- RUN, redirect request, rib_hold_req_i=0: latch winning address, state→JUMP.
- RUN, redirect request, rib_hold_req_i=1: latch winning address into pending, state→PEND, hold_flag_o=1.
- PEND:
  - A later request of strictly higher priority overwrites the pending address. Equal or lower priority is ignored.
  - When rib_hold_req_i=0: state→JUMP.
- JUMP (exactly 1 cycle):
  - jump_flag_o=1, jump_addr_o=latched address, hold_flag_o=3.
  - Requests arriving in this cycle are ignored (they are squashed instructions).
  - Load counter with FLUSH_CYCLES, state→FLUSH.
- FLUSH:
  - hold_flag_o=3, counter decrements each cycle.
  - At counter==1: state→RUN.
  - Redirect requests are ignored; the stages are being flushed.
- HALT entry:
  - jtag_halt_req_i=1 in RUN: state→HALT.
  - In PEND, JUMP or FLUSH: HALT is entered only after that sequence reaches RUN.
- HALT:
  - hold_flag_o=3, halted_o=1. ex/clint requests ignored.
  - On deassert: next cycle halted_o=0, hold_flag_o=0, state→RUN.
- Stall in RUN with no redirect:
  - hold_flag_o = 3 if ex_hold_req_i|clint_hold_req_i, else 1 if rib_hold_req_i, else 0.
  - jump_flag_o=0.
- Simultaneous ex_jump and clint_int in the same cycle: clint wins; the ex request is dropped and not queued.
- jump_flag_o is never high in two consecutive cycles.

Optional Feature:
- Macro PC_FLOW_CTRL_STAT_EN.
- When defined, adds outputs stat_redirect_cnt_o[31:0] and stat_hold_cnt_o[31:0]:
  - stat_redirect_cnt_o counts jump_flag_o pulses.
  - stat_hold_cnt_o counts cycles with hold_flag_o!=0.
  - Both wrap at 2^32 and clear on rst or jtag_reset_flag_o.
- When undefined, the ports and counters are absent.

Test Plan:
- Reset → all outputs zero, jump_addr_o=RESET_ADDR. ex_jump_req_i=1 with addr 0x100 for one cycle → jump_flag_o=1 with jump_addr_o=0x100 one cycle later, then hold_flag_o=3 for 2 cycles (FLUSH_CYCLES=2), then 0.
- ex_jump (0x200) and clint_int (0x80) in the same cycle → single pulse to 0x80; no later pulse to 0x200.
- rib_hold_req_i=1 for 5 cycles while ex_jump 0x300 arrives, clint 0x40 arrives in the 3rd busy cycle → hold_flag_o=1 during the busy cycles, then one pulse to 0x40 after rib drops.
- jtag_halt_req_i during FLUSH → halted_o rises only after FLUSH ends. Release → halted_o=0 next cycle. ex_jump during HALT → no pulse.
- jtag_reset_req_i during PEND → jtag_reset_flag_o=1 next cycle, pending discarded, no jump pulse after release.
- With PC_FLOW_CTRL_STAT_EN, three redirects → stat_redirect_cnt_o=3, stat_hold_cnt_o equals counted hold cycles.

Source files
------------

// File: rtl/pc_flow_ctrl.sv
// PC/front-end flow controller: redirect arbitration, bus-busy deferral, flush and debug halt.
// Optional statistics counters are built when PC_FLOW_CTRL_STAT_EN is defined.
module pc_flow_ctrl #(
  parameter int unsigned          ADDR_W       = 32,
  parameter logic [ADDR_W-1:0]    RESET_ADDR   = '0,
  parameter int unsigned          FLUSH_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_jump_req_i,
  input  logic [ADDR_W-1:0] ex_jump_addr_i,
  input  logic              ex_hold_req_i,
  input  logic              clint_int_req_i,
  input  logic [ADDR_W-1:0] clint_int_addr_i,
  input  logic              clint_hold_req_i,
  input  logic              rib_hold_req_i,
  input  logic              jtag_halt_req_i,
  input  logic              jtag_reset_req_i,
  output logic              jump_flag_o,
  output logic [ADDR_W-1:0] jump_addr_o,
  output logic [2:0]        hold_flag_o,
`ifdef PC_FLOW_CTRL_STAT_EN
  output logic [31:0]       stat_redirect_cnt_o,
  output logic [31:0]       stat_hold_cnt_o,
`endif
  output logic              jtag_reset_flag_o,
  output logic              halted_o
);

  typedef enum logic [2:0] {
    S_RUN, S_PEND, S_JUMP, S_FLUSH, S_HALT
  } state_e;

  localparam logic [2:0] HOLD_NONE = 3'd0;
  localparam logic [2:0] HOLD_PC   = 3'd1;
  localparam logic [2:0] HOLD_ALL  = 3'd3;
  localparam logic [3:0] FLUSH_LD  = 4'(FLUSH_CYCLES);
  localparam logic [1:0] PRIO_EX   = 2'd1;
  localparam logic [1:0] PRIO_INT  = 2'd2;

  state_e            state_q, state_d;
  logic              jump_flag_q, jump_flag_d;
  logic [ADDR_W-1:0] jump_addr_q, jump_addr_d;
  logic [2:0]        hold_q, hold_d;
  logic              jrst_q, jrst_d;
  logic              halted_q, halted_d;
  logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
  logic [1:0]        pend_prio_q, pend_prio_d;
  logic [3:0]        cnt_q, cnt_d;

  logic              req_any;
  logic [1:0]        req_prio;
  logic [ADDR_W-1:0] req_addr;
  logic [2:0]        stall_lvl;
  logic [ADDR_W-1:0] pend_upd;
  logic              pend_win;

  // clint beats ex; a losing ex request is simply dropped
  assign req_any   = clint_int_req_i | ex_jump_req_i;
  assign req_prio  = clint_int_req_i ? PRIO_INT : PRIO_EX;
  assign req_addr  = clint_int_req_i ? clint_int_addr_i
                                     : ex_jump_addr_i;
  assign stall_lvl = (ex_hold_req_i | clint_hold_req_i) ? HOLD_ALL :
                     rib_hold_req_i ? HOLD_PC : HOLD_NONE;
  assign pend_win  = clint_int_req_i && (pend_prio_q < PRIO_INT);
  assign pend_upd  = pend_win ? clint_int_addr_i : pend_addr_q;

  always_comb begin
    state_d     = state_q;
    jump_flag_d = 1'b0;
    jump_addr_d = jump_addr_q;
    hold_d      = HOLD_NONE;
    jrst_d      = 1'b0;
    halted_d    = 1'b0;
    pend_addr_d = pend_addr_q;
    pend_prio_d = pend_prio_q;
    cnt_d       = cnt_q;
    if (jtag_reset_req_i) begin
      jrst_d      = 1'b1;
      hold_d      = HOLD_ALL;
      jump_addr_d = RESET_ADDR;
      pend_prio_d = '0;
      cnt_d       = '0;
      state_d     = S_RUN;
    end else begin
      unique case (state_q)
        S_RUN: begin
          if (jtag_halt_req_i) begin
            state_d  = S_HALT;
            halted_d = 1'b1;
            hold_d   = HOLD_ALL;
          end else if (req_any && rib_hold_req_i) begin
            state_d     = S_PEND;
            pend_addr_d = req_addr;
            pend_prio_d = req_prio;
            hold_d      = HOLD_PC;
          end else if (req_any) begin
            state_d     = S_JUMP;
            jump_flag_d = 1'b1;
            jump_addr_d = req_addr;
            hold_d      = HOLD_ALL;
          end else begin
            hold_d = stall_lvl;
          end
        end
        S_PEND: begin
          pend_addr_d = pend_upd;
          if (pend_win) pend_prio_d = PRIO_INT;
          if (!rib_hold_req_i) begin
            state_d     = S_JUMP;
            jump_flag_d = 1'b1;
            jump_addr_d = pend_upd;
            pend_prio_d = '0;
            hold_d      = HOLD_ALL;
          end else begin
            hold_d = HOLD_PC;
          end
        end
        S_JUMP: begin
          state_d = S_FLUSH;
          cnt_d   = FLUSH_LD;
          hold_d  = HOLD_ALL;
        end
        S_FLUSH: begin
          if (cnt_q > 4'd1) begin
            cnt_d  = cnt_q - 4'd1;
            hold_d = HOLD_ALL;
          end else begin
            cnt_d   = '0;
            state_d = S_RUN;
            hold_d  = stall_lvl;
          end
        end
        S_HALT: begin
          if (jtag_halt_req_i) begin
            halted_d = 1'b1;
            hold_d   = HOLD_ALL;
          end else begin
            state_d = S_RUN;
          end
        end
        default: state_d = S_RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_RUN;
      jump_flag_q <= 1'b0;
      jump_addr_q <= RESET_ADDR;
      hold_q      <= HOLD_NONE;
      jrst_q      <= 1'b0;
      halted_q    <= 1'b0;
      pend_addr_q <= RESET_ADDR;
      pend_prio_q <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      jump_flag_q <= jump_flag_d;
      jump_addr_q <= jump_addr_d;
      hold_q      <= hold_d;
      jrst_q      <= jrst_d;
      halted_q    <= halted_d;
      pend_addr_q <= pend_addr_d;
      pend_prio_q <= pend_prio_d;
      cnt_q       <= cnt_d;
    end
  end

  assign jump_flag_o       = jump_flag_q;
  assign jump_addr_o       = jump_addr_q;
  assign hold_flag_o       = hold_q;
  assign jtag_reset_flag_o = jrst_q;
  assign halted_o          = halted_q;

`ifdef PC_FLOW_CTRL_STAT_EN
  logic [31:0] redir_cnt_q, redir_cnt_d;
  logic [31:0] hold_cnt_q, hold_cnt_d;

  always_comb begin
    redir_cnt_d = redir_cnt_q;
    hold_cnt_d  = hold_cnt_q;
    if (jrst_q) begin
      redir_cnt_d = '0;
      hold_cnt_d  = '0;
    end else begin
      if (jump_flag_q) redir_cnt_d = redir_cnt_q + 32'd1;
      if (hold_q != HOLD_NONE) hold_cnt_d = hold_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      redir_cnt_q <= '0;
      hold_cnt_q  <= '0;
    end else begin
      redir_cnt_q <= redir_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
    end
  end

  assign stat_redirect_cnt_o = redir_cnt_q;
  assign stat_hold_cnt_o     = hold_cnt_q;
`endif

endmodule

// File: tb/tb_pc_flow_ctrl.sv
// Bench for pc_flow_ctrl: directed scenarios plus random traffic
// against a behavioural model of the redirect/stall rules.
module tb_pc_flow_ctrl;

  localparam int FL = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_jump_req, ex_hold_req;
  logic [31:0] ex_jump_addr, clint_int_addr;
  logic        clint_int_req, clint_hold_req;
  logic        rib_hold_req, jtag_halt_req, jtag_reset_req;
  logic        jump_flag, jtag_reset_flag, halted;
  logic [31:0] jump_addr;
  logic [2:0]  hold_flag;
`ifdef PC_FLOW_CTRL_STAT_EN
  logic [31:0] stat_redir, stat_hold;
`endif

  int checks = 0;
  int errors = 0;

  pc_flow_ctrl #(
    .ADDR_W(32), .RESET_ADDR(32'h0), .FLUSH_CYCLES(FL)
  ) dut (
    .clk(clk), .rst(rst),
    .ex_jump_req_i(ex_jump_req),
    .ex_jump_addr_i(ex_jump_addr),
    .ex_hold_req_i(ex_hold_req),
    .clint_int_req_i(clint_int_req),
    .clint_int_addr_i(clint_int_addr),
    .clint_hold_req_i(clint_hold_req),
    .rib_hold_req_i(rib_hold_req),
    .jtag_halt_req_i(jtag_halt_req),
    .jtag_reset_req_i(jtag_reset_req),
    .jump_flag_o(jump_flag),
    .jump_addr_o(jump_addr),
    .hold_flag_o(hold_flag),
`ifdef PC_FLOW_CTRL_STAT_EN
    .stat_redirect_cnt_o(stat_redir),
    .stat_hold_cnt_o(stat_hold),
`endif
    .jtag_reset_flag_o(jtag_reset_flag),
    .halted_o(halted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // model: what the controller is busy with, and expected outputs
  string       m_mode = "run";
  int          m_left = 0;
  logic [31:0] m_pend = 0;
  int          m_rank = 0;
  logic        e_jf = 0, e_jr = 0, e_halt = 0;
  logic [31:0] e_ja = 0;
  int          e_hold = 0;
  int          n_pulse = 0;
  int unsigned e_sredir = 0, e_shold = 0;

  task automatic fire(input logic [31:0] a);
    m_mode = "jump";
    m_rank = 0;
    e_jf   = 1;
    e_ja   = a;
    e_hold = 3;
  endtask

  task automatic step(input logic r, input logic ej,
                      input logic [31:0] ea, input logic eh,
                      input logic ci, input logic [31:0] ca,
                      input logic ch, input logic rb,
                      input logic hl, input logic jr);
    int stall;
    rst = r; ex_jump_req = ej; ex_jump_addr = ea;
    ex_hold_req = eh; clint_int_req = ci;
    clint_int_addr = ca; clint_hold_req = ch;
    rib_hold_req = rb; jtag_halt_req = hl;
    jtag_reset_req = jr;
    stall = (eh || ch) ? 3 : (rb ? 1 : 0);
    if (r || e_jr) begin
      e_sredir = 0; e_shold = 0;
    end else begin
      e_sredir += e_jf ? 1 : 0;
      e_shold  += (e_hold != 0) ? 1 : 0;
    end
    if (r) begin
      m_mode = "run"; m_rank = 0; m_left = 0;
      e_jf = 0; e_ja = 0; e_hold = 0; e_jr = 0; e_halt = 0;
    end else if (jr) begin
      m_mode = "run"; m_rank = 0; m_left = 0;
      e_jf = 0; e_ja = 0; e_hold = 3; e_jr = 1; e_halt = 0;
    end else begin
      e_jf = 0; e_jr = 0; e_halt = 0; e_hold = 0;
      case (m_mode)
        "run":
          if (hl) begin
            m_mode = "halt"; e_halt = 1; e_hold = 3;
          end else if (ci || ej) begin
            if (rb) begin
              m_mode = "pend"; e_hold = 1;
              m_pend = ci ? ca : ea;
              m_rank = ci ? 2 : 1;
            end else fire(ci ? ca : ea);
          end else e_hold = stall;
        "pend": begin
          if (ci && m_rank < 2) begin
            m_pend = ca; m_rank = 2;
          end
          if (!rb) fire(m_pend);
          else e_hold = 1;
        end
        "jump": begin
          m_mode = "flush"; m_left = FL; e_hold = 3;
        end
        "flush":
          if (m_left > 1) begin
            m_left--; e_hold = 3;
          end else begin
            m_mode = "run"; e_hold = stall;
          end
        default:
          if (hl) begin
            e_halt = 1; e_hold = 3;
          end else m_mode = "run";
      endcase
    end
    @(posedge clk);
    #1;
    n_pulse += jump_flag ? 1 : 0;
    chk("jump_flag", {31'b0, jump_flag}, {31'b0, e_jf});
    chk("hold_flag", {29'b0, hold_flag}, e_hold);
    chk("jtag_rst", {31'b0, jtag_reset_flag}, {31'b0, e_jr});
    chk("halted", {31'b0, halted}, {31'b0, e_halt});
    if (e_jf) chk("jump_addr", jump_addr, e_ja);
`ifdef PC_FLOW_CTRL_STAT_EN
    chk("stat_redir", stat_redir, e_sredir);
    chk("stat_hold", stat_hold, e_shold);
`endif
  endtask

  task automatic idle(input int n, input logic hl = 0);
    for (int i = 0; i < n; i++)
      step(0, 0, 0, 0, 0, 0, 0, 0, hl, 0);
  endtask

  logic halt_l, rib_l;

  initial begin
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("reset_addr", jump_addr, 32'h0);
    idle(2);
    // plain EX redirect then flush window
    step(0, 1, 32'h100, 0, 0, 0, 0, 0, 0, 0);
    chk("ex_target", jump_addr, 32'h100);
    idle(4);
    // simultaneous EX and CLINT: single pulse to CLINT
    n_pulse = 0;
    step(0, 1, 32'h200, 0, 1, 32'h80, 0, 0, 0, 0);
    chk("clint_wins", jump_addr, 32'h80);
    idle(6);
    chk("one_pulse", n_pulse, 1);
    // bus busy with EX then higher-priority CLINT
    n_pulse = 0;
    step(0, 1, 32'h300, 0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 1, 32'h40, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("pend_target", jump_addr, 32'h40);
    idle(5);
    chk("pend_pulses", n_pulse, 1);
    // halt during jump/flush, EX ignored while halted
    step(0, 1, 32'h100, 0, 0, 0, 0, 0, 0, 0);
    idle(4, 1);
    n_pulse = 0;
    step(0, 1, 32'h500, 0, 0, 0, 0, 0, 1, 0);
    idle(3, 1);
    idle(4);
    chk("halt_no_pulse", n_pulse, 0);
    // JTAG reset discards a pending redirect
    n_pulse = 0;
    step(0, 1, 32'h600, 0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    idle(5);
    chk("jrst_discard", n_pulse, 0);
    // random traffic
    halt_l = 0; rib_l = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 29) == 0) halt_l = !halt_l;
      if ($urandom_range(0, 3) == 0) rib_l = !rib_l;
      step(($urandom_range(0, 499) == 0),
           ($urandom_range(0, 3) == 0),
           $urandom() & 32'hFFFF_FFFC,
           ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 7) == 0),
           $urandom() & 32'hFFFF_FFFC,
           ($urandom_range(0, 5) == 0),
           rib_l, halt_l,
           ($urandom_range(0, 59) == 0));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
